// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_xcvr transceiver.
// The parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic bit cfg_legal(input int data_bits, input int stop_bits);
        return (data_bits >= 5) && (data_bits <= 8) && (stop_bits == 1 || stop_bits == 2);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; a divisor of 0 behaves as 1.
// A new divisor is picked up at the next reload.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (tick_o) begin
            cnt_d = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex 16x-oversampled UART with valid/ready on both data paths.
// Define UART_PARITY_EN to add a parity bit to both directions.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_odd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    if (!cfg_legal(DATA_BITS, STOP_BITS)) begin : g_bad_cfg
        $error("uart_xcvr: DATA_BITS must be 5..8 and STOP_BITS 1 or 2");
    end

    localparam logic [4:0] TX_LAST_TICK = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] TX_STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [3:0] RX_MID_TICK  = 4'(SAMPLE_TICK - 1);
    localparam logic [3:0] RX_LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_i      (clk),
        .rst_i      (rst),
        .baud_div_i (baud_div),
        .tick_o     (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e            tx_st_q, tx_st_d;
    logic [4:0]           tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_dat_q, tx_dat_d;
    logic                 tx_q, tx_d;
    logic                 tx_par;

    assign tx_ready = (tx_st_q == TX_IDLE);
    assign tx       = tx_q;

`ifdef UART_PARITY_EN
    assign tx_par = (^tx_dat_q) ^ parity_odd;
`else
    assign tx_par = 1'b1;
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_dat_d = tx_dat_q;
        case (tx_st_q)
            TX_IDLE: if (tx_valid) begin
                tx_dat_d = tx_data;
                tx_cnt_d = '0;
                tx_bit_d = '0;
                tx_st_d  = TX_START;
            end
            TX_START: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == TX_LAST_TICK) begin
                    tx_cnt_d = '0;
                    tx_st_d  = TX_DATA;
                end
            end
            TX_DATA: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == TX_LAST_TICK) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_st_d = TX_PARITY;
`else
                        tx_st_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == TX_LAST_TICK) begin
                    tx_cnt_d = '0;
                    tx_st_d  = TX_STOP;
                end
            end
`endif
            TX_STOP: if (tick) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == TX_STOP_LAST) begin
                    tx_cnt_d = '0;
                    tx_st_d  = TX_IDLE;
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase

        // Line level follows the next state so tx changes together with the state.
        case (tx_st_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_dat_q[tx_bit_d];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_dat_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_dat_q <= tx_dat_d;
            tx_q     <= tx_d;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e            rx_st_q, rx_st_d;
    logic                 rx_s1_q, rx_s2_q;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_mid, rx_last, rx_done;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_pop;

    assign rx_mid  = tick && (rx_cnt_q == RX_MID_TICK);
    assign rx_last = tick && (rx_cnt_q == RX_LAST_TICK);

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = tick ? rx_cnt_q + 1'b1 : rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_perr_d = rx_perr_q;
        rx_done   = 1'b0;
        case (rx_st_q)
            // IDLE is only entered with the line high, so a low level is a falling edge.
            RX_IDLE: begin
                rx_cnt_d  = '0;
                rx_bit_d  = '0;
                rx_perr_d = 1'b0;
                if (!rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: begin
                if (rx_mid && rx_s2_q) rx_st_d = RX_IDLE;
                else if (rx_last)      rx_st_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_mid) rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_last) begin
                    if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_st_d = RX_PARITY;
`else
                        rx_st_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_mid)  rx_perr_d = rx_s2_q ^ (^rx_sh_q) ^ parity_odd;
                if (rx_last) rx_st_d   = RX_STOP;
            end
`endif
            RX_STOP: if (rx_mid) begin
                rx_done = 1'b1;
                rx_st_d = rx_s2_q ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: if (rx_s2_q) rx_st_d = RX_IDLE;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // A pop in the same cycle as a completed frame frees the slot, so no overrun.
    always_comb begin
        rx_pop     = rx_valid_q && rx_ready;
        rx_valid_d = rx_valid_q && !rx_pop;
        rx_data_d  = rx_data_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        ovr_d      = 1'b0;
        if (rx_done) begin
            if (!rx_valid_q || rx_pop) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
                ferr_d     = !rx_s2_q;
                perr_d     = rx_perr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_perr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr with a receive scoreboard; TX can be looped to RX
// or RX driven directly. Parity cases run when UART_PARITY_EN is defined.
module tb_uart_xcvr;

    localparam int BIT = 64;  // 16 ticks x baud_div 4
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic        parity_odd = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx;
    logic        rx_line;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        frame_err, parity_err, overrun;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0, rx_cnt = 0, ovr_cnt = 0;

    always #5 clk = ~clk;
    assign rx_line = loop ? tx : rx_drv;

    uart_xcvr #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .rx         (rx_line),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // Receive monitor: every pop is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && overrun) ovr_cnt++;
        if (!rst && rx_valid && rx_ready) begin
            rx_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rx_unexpected: observed data %0h, expected no frame", rx_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_frame{data,fe,pe}", {22'd0, rx_data, frame_err, parity_err}, {22'd0, e});
            end
        end
    end

    task automatic tx_send(input logic [7:0] d, output int low);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 3000) begin cyc1(); n++; end
        cyc1();
        tx_valid = 1'b0;
        low = 0;
        while (!tx_ready && low < 3000) begin cyc1(); low++; end
        chk("tx_done_in_time", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        rx_drv = 1'b0;
        repeat (BIT) cyc1();
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT) cyc1();
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ parity_odd ^ bad_par;
        repeat (BIT) cyc1();
`endif
        rx_drv = stop;
        repeat (BIT) cyc1();
    endtask

    initial begin
        int low, base, ovr0, n;

        // reset state
        repeat (3) cyc1();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (5) cyc1();

        // single frame in loopback
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        tx_send(8'hA5, low);
        chk("tx_ready_low_window", {31'd0, (low >= NBITS*BIT-4 && low <= NBITS*BIT+4)}, 32'd1);
        repeat (10) cyc1();
        chk("single_rx_count", rx_cnt, 1);

        // back-to-back with tx_valid held
        sb.push_back('{8'h00, 1'b0, 1'b0});
        sb.push_back('{8'hFF, 1'b0, 1'b0});
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cyc1();
        tx_data = 8'hFF;
        n = 0;
        while (!tx_ready && n < 3000) begin cyc1(); n++; end
        chk("b2b_first_done", {31'd0, tx_ready}, 32'd1);
        cyc1();
        chk("b2b_no_idle_bit_tx", {31'd0, tx}, 32'd0);
        chk("b2b_ready_drop", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 3000) begin cyc1(); n++; end
        repeat (10) cyc1();
        chk("b2b_rx_count", rx_cnt, 3);

        // glitch rejection
        loop = 1'b0;
        repeat (BIT) cyc1();
        base   = rx_cnt;
        rx_drv = 1'b0;
        repeat (12) cyc1();
        rx_drv = 1'b1;
        repeat (2*BIT) cyc1();
        chk("glitch_no_rx", rx_cnt, base);
        sb.push_back('{8'h5A, 1'b0, 1'b0});
        drive_frame(8'h5A, 1'b0, 1'b1);
        repeat (BIT) cyc1();
        chk("glitch_then_frame", rx_cnt, base + 1);

        // frame error followed by break
        base = rx_cnt;
        sb.push_back('{8'h3C, 1'b1, 1'b0});
        drive_frame(8'h3C, 1'b0, 1'b0);
        repeat (20*BIT) cyc1();
        chk("break_single_rx", rx_cnt, base + 1);
        rx_drv = 1'b1;
        repeat (3*BIT) cyc1();
        chk("break_release_quiet", rx_cnt, base + 1);
        sb.push_back('{8'hC3, 1'b0, 1'b0});
        drive_frame(8'hC3, 1'b0, 1'b1);
        repeat (BIT) cyc1();
        chk("break_resync_frame", rx_cnt, base + 2);

        // overrun
        loop     = 1'b1;
        rx_ready = 1'b0;
        ovr0     = ovr_cnt;
        sb.push_back('{8'h11, 1'b0, 1'b0});
        tx_send(8'h11, low);
        tx_send(8'h22, low);
        repeat (4) cyc1();
        chk("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("ovr_data_held", {24'd0, rx_data}, 32'h11);
        chk("ovr_pulse_count", ovr_cnt - ovr0, 1);
        rx_ready = 1'b1;
        repeat (2*BIT) cyc1();
        chk("ovr_no_second_frame", {31'd0, rx_valid}, 32'd0);
        chk("ovr_sb_drained", sb.size(), 0);

`ifdef UART_PARITY_EN
        // parity bit on the wire and injected parity error
        parity_odd = 1'b0;
        sb.push_back('{8'h07, 1'b0, 1'b0});
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        cyc1();
        tx_valid = 1'b0;
        repeat (9*BIT + BIT/2) cyc1();
        chk("parity_bit_07", {31'd0, tx}, 32'd1);
        n = 0;
        while (!tx_ready && n < 3000) begin cyc1(); n++; end
        repeat (10) cyc1();
        loop = 1'b0;
        sb.push_back('{8'h33, 1'b0, 1'b1});
        drive_frame(8'h33, 1'b1, 1'b1);
        repeat (BIT) cyc1();
        chk("parity_err_sb_drained", sb.size(), 0);
        loop = 1'b1;
`endif

        // reset in the middle of DATA
        base     = rx_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        cyc1();
        tx_valid = 1'b0;
        repeat (3*BIT) cyc1();
        chk("mid_busy_before_rst", {31'd0, tx_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        repeat (3) cyc1();
        rst = 1'b0;
        repeat (12*BIT) cyc1();
        chk("mid_rst_no_rx", rx_cnt, base);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
